mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles while another requester waits (legal range 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per requester; req[i] held high while requester i needs the shared 4:1 mux.
REQ-005 din  input  4  data bit per requester; din[i] is mux input i.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 sel1  output  1  registered mux select MSB (owner index bit 1).
REQ-008 sel0  output  1  registered mux select LSB (owner index bit 0).
REQ-009 out  output  1  shared mux output: din[{sel1,sel0}] while gnt nonzero, else 0.
REQ-010 busy  output  1  high while state is GRANT.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-012 IDLE: if req nonzero at a rising edge, the block SHALL pick the winner, go to GRANT, and set gnt/sel on that edge. Grant latency is 1 cycle from the sampled request.
REQ-013 Winner selection SHALL be round-robin: search from index (ptr+1) mod 4 upward, wrapping 3->0. The first asserted req wins. ptr is the last released owner.
REQ-014 GRANT: gnt SHALL equal one-hot of owner, {sel1,sel0} SHALL equal owner index, and busy=1.
REQ-015 hold counter (4-bit) SHALL clear on grant entry and increment each GRANT cycle.
REQ-016 In GRANT, if req[owner]=0 at an edge, the block SHALL go to RELEASE. This takes priority over preemption.
REQ-017 In GRANT, if counter = MAX_HOLD-1 and any other req bit is high, the block SHALL go to RELEASE (forced preemption).
REQ-018 In GRANT, if counter reaches MAX_HOLD-1 with no other request, the counter SHALL saturate and the grant SHALL be kept.
REQ-019 On entry to RELEASE, gnt SHALL become 0, busy 0, and ptr SHALL be set to the owner index.
REQ-020 {sel1,sel0} SHALL keep the last owner index when no grant is active.
REQ-021 RELEASE SHALL last exactly 1 cycle and then go to IDLE unconditionally. The minimum gap between consecutive grants is 2 cycles with no gnt asserted.
REQ-022 gnt SHALL never have more than one bit set; gnt and busy SHALL change only on clock edges.
REQ-023 out SHALL be combinational from din and registered sel/gnt, with no added latency.
REQ-024 Request changes on non-owner lines during GRANT SHALL NOT affect owner, sel or counter, except through REQ-017.
REQ-025 Simultaneous deassertion of req[owner] and the preemption condition SHALL be treated as deassertion (REQ-016).

Reset
REQ-026 While rst_n=0, asynchronously: state=IDLE, gnt=0000, sel1=0, sel0=0, out=0, busy=0, counter=0, ptr=3 (requester 0 has first priority after reset).
REQ-027 Reset asserted mid-GRANT SHALL drop the grant immediately, without waiting for a clock edge.
REQ-028 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with req nonzero.

Verification
REQ-029 Single requester: req=0100, din=0100 -> next edge gnt=0100, sel1=1, sel0=0, out=1, busy=1. Drop req -> RELEASE (gnt=0000, out=0), then IDLE.
REQ-030 Round-robin: after reset, req=1111 held -> grant order 0,1,2,3,0. Each grant lasts MAX_HOLD cycles followed by a 2-cycle gap. sel sequence 00,01,10,11,00.
REQ-031 No contention: req=0010 held 20 cycles with MAX_HOLD=8 -> gnt=0010 for all 20 cycles and counter saturates at 7. Raise req[3] -> gnt drops within 1 cycle, next owner is 3.
REQ-032 Simultaneous events: owner 1 drops req in the same cycle the counter hits 7 with req[2]=1 -> RELEASE, ptr=1, next grant=2.
REQ-033 Reset mid-grant: gnt=1000, pull rst_n low between edges -> gnt=0000, sel=00, out=0, busy=0 immediately. After release with req=1001 -> owner 0 granted first.
REQ-034 Data path: owner 3, toggle din[3] 0->1->0 and din[0..2] randomly -> out follows din[3] only. All checks are self-checking via $display-compare on each edge.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 single-bit mux.
// Hold limit forces a release only when another requester is waiting.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       sel1,
    output logic       sel0,
    output logic       out,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [1:0] r_ptr,   w_ptr_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [3:0] r_gnt,   w_gnt_nxt;
    logic       r_busy,  w_busy_nxt;
    logic [1:0] w_win;
    logic       w_win_vld;
    logic       w_others;

    // Scan from farthest to nearest so the requester closest after r_ptr wins.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win     = r_ptr + 2'(k);
                w_win_vld = 1'b1;
            end
        end
    end

    assign w_others = |(req & ~r_gnt);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_win;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_GRANT: begin
                // Owner dropping its request wins over a simultaneous preemption.
                if (!req[r_owner] || (r_cnt == CNT_MAX && w_others)) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = r_owner;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Select keeps the last owner index between grants.
    assign gnt  = r_gnt;
    assign sel1 = r_owner[1];
    assign sel0 = r_owner[0];
    assign busy = r_busy;
    assign out  = (|r_gnt) ? din[r_owner] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed plus randomized bench for mux4_rr_arbiter against a cycle-level
// model that tracks owner, cycles held and last released owner.
module tb_mux4_rr_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] din = '0;
    logic [3:0] gnt;
    logic       sel1, sel0, out, busy;

    int checks = 0;
    int errors = 0;

    int         m_owner;
    int         m_held;
    int         m_gap;
    int         m_last;
    logic [1:0] m_sel;

    mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt), .sel1(sel1), .sel0(sel0), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_gap = 0; m_last = 3; m_sel = 2'd0;
    endtask

    // Applies the arbitration rules to the inputs sampled at the coming edge.
    task automatic model_edge();
        if (m_owner >= 0) begin
            if (!req[m_owner] || (m_held >= MH && (req & ~(4'b0001 << m_owner)) != 4'b0)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
        end else if (req != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (req[i]) begin
                    m_owner = i; m_held = 1; m_sel = 2'(i);
                    break;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_gnt;
        logic       e_out;
        e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e_out = (m_owner >= 0) ? din[m_owner] : 1'b0;
        chk({tag, ".gnt"},  8'(gnt), 8'(e_gnt));
        chk({tag, ".sel"},  8'({sel1, sel0}), 8'(m_sel));
        chk({tag, ".busy"}, 8'(busy), 8'(m_owner >= 0));
        chk({tag, ".out"},  8'(out), 8'(e_out));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int order[$];
        int lens[$];
        int run;
        logic [3:0] prev;

        model_reset();
        #2;
        chk("rst.gnt",  8'(gnt), 8'h0);
        chk("rst.sel",  8'({sel1, sel0}), 8'h0);
        chk("rst.busy", 8'(busy), 8'h0);
        chk("rst.out",  8'(out), 8'h0);
        do_reset();

        // Single requester
        req = 4'b0100; din = 4'b0100;
        tick("single.grant");
        chk("single.gnt", 8'(gnt), 8'h4);
        chk("single.sel", 8'({sel1, sel0}), 8'h2);
        chk("single.out", 8'(out), 8'h1);
        req = 4'b0000;
        tick("single.release");
        chk("single.rel_gnt", 8'(gnt), 8'h0);
        chk("single.rel_sel", 8'({sel1, sel0}), 8'h2);
        tick("single.idle");

        // Round-robin with all requesting
        do_reset();
        req = 4'b1111; din = 4'b1010;
        prev = '0; run = 0;
        for (int c = 0; c < 45; c++) begin
            tick("rr");
            if (gnt != 0 && prev == 0) order.push_back(int'({sel1, sel0}));
            if (gnt != 0) run++;
            if (gnt == 0 && prev != 0) begin lens.push_back(run); run = 0; end
            prev = gnt;
        end
        chk("rr.count", 8'(order.size()), 8'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk($sformatf("rr.order%0d", i), 8'(order[i]), 8'(i % 4));
        for (int i = 0; i < 4 && i < lens.size(); i++) chk($sformatf("rr.len%0d", i), 8'(lens[i]), 8'(MH));

        // No contention: saturate, then preempt by requester 3
        do_reset();
        req = 4'b0010;
        tick("sat.grant");
        for (int c = 0; c < 20; c++) begin
            tick("sat.hold");
            chk("sat.gnt", 8'(gnt), 8'h2);
        end
        req = 4'b1010;
        tick("sat.preempt");
        chk("sat.drop", 8'(gnt), 8'h0);
        tick("sat.gap");
        tick("sat.next");
        chk("sat.next_gnt", 8'(gnt), 8'h8);

        // Owner drop coincides with hold limit
        do_reset();
        req = 4'b0010;
        tick("sim.grant");
        for (int c = 0; c < MH - 1; c++) tick("sim.hold");
        req = 4'b0100;
        tick("sim.release");
        chk("sim.rel_gnt", 8'(gnt), 8'h0);
        tick("sim.idle");
        tick("sim.next");
        chk("sim.next_gnt", 8'(gnt), 8'h4);

        // Reset between edges while requester 3 owns the mux
        do_reset();
        req = 4'b1000; din = 4'b1000;
        tick("arst.grant");
        chk("arst.pre_gnt", 8'(gnt), 8'h8);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.gnt",  8'(gnt), 8'h0);
        chk("arst.sel",  8'({sel1, sel0}), 8'h0);
        chk("arst.out",  8'(out), 8'h0);
        chk("arst.busy", 8'(busy), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001;
        tick("arst.after");
        chk("arst.first", 8'(gnt), 8'h1);

        // Data path follows the owner's input only
        do_reset();
        req = 4'b1000; din = 4'b0000;
        tick("dp.grant");
        for (int c = 0; c < 6; c++) begin
            din = {1'(c % 2), 3'($urandom_range(0, 7))};
            #1;
            chk("dp.out", 8'(out), 8'(din[3]));
            tick("dp.tick");
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            din = 4'($urandom_range(0, 15));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
